quad_position: RTL
==================

QUAD_POSITION -- requirements
Module: quad_position

Interface
REQ-001 Parameter POS_W, default 10, width of position output.
REQ-002 Parameter POS_MAX, default 639, upper saturation bound of position.
REQ-003 Parameter POS_INIT, default 320, position loaded at reset and recenter.
REQ-004 Parameter DETENT, default 4, quarter-steps per reported step; legal values 1, 2 and 4.
REQ-005 clk  input  1  single system clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 Ain  input  1  debounced encoder channel A, synchronous to clk.
REQ-008 Bin  input  1  debounced encoder channel B, synchronous to clk.
REQ-009 recenter  input  1  synchronous request to reload POS_INIT.
REQ-010 step_pulse  output  1  one-cycle strobe per accepted detent.
REQ-011 dir  output  1  direction of last step: 1 = clockwise (increment), 0 = counter-clockwise.
REQ-012 pos  output  POS_W  saturating cursor position, 0..POS_MAX.
REQ-013 at_min / at_max  output  1 each  pos == 0 / pos == POS_MAX, combinational from pos register.
REQ-014 err_pulse  output  1  one-cycle strobe on illegal double-bit transition.

Function
REQ-015 Ain/Bin SHALL be registered once into cur_ab; previous sample held in prev_ab; decode compares prev_ab -> cur_ab.
REQ-016 Gray order {B,A}: 00->01->11->10->00 SHALL be INC; reverse order SHALL be DEC; equal SHALL be NONE; 00<->11 or 01<->10 SHALL be ILLEGAL.
REQ-017 Signed quarter accumulator acc SHALL range -(DETENT-1)..+(DETENT-1); INC adds 1, DEC subtracts 1.
REQ-018 When acc would reach +DETENT: acc <= 0, step_pulse=1, dir=1, pos increments unless pos == POS_MAX.
REQ-019 When acc would reach -DETENT: acc <= 0, step_pulse=1, dir=0, pos decrements unless pos == 0.
REQ-020 Saturated step SHALL still assert step_pulse and update dir; pos stays unchanged.
REQ-021 ILLEGAL SHALL assert err_pulse one cycle, leave acc, pos and dir unchanged, and still update prev_ab.
REQ-022 Latency: the input edge completing a detent SHALL be visible on step_pulse/pos exactly 2 clk edges later (1 input register + 1 output register).
REQ-023 step_pulse and err_pulse SHALL never be high for more than one consecutive cycle per qualifying transition.
REQ-024 recenter SHALL load pos=POS_INIT, acc=0 next cycle and suppress any step_pulse that cycle; dir and err_pulse unaffected; prev_ab still tracks input.
REQ-025 Direction reversal mid-detent SHALL unwind acc without emitting a step (e.g. INC, INC, DEC, DEC -> acc 0, no pulse).

Reset
REQ-026 While rst_n=0 at a clk edge: pos=POS_INIT, acc=0, dir=0, step_pulse=0, err_pulse=0, cur_ab=00, prev_ab=00.
REQ-027 First cycle after rst_n deasserts SHALL be a prime cycle: prev_ab and cur_ab load the input, no decode, no pulses; prevents false step from reset value 00.
REQ-028 Reset mid-detent SHALL discard partial acc; no pulse on the releasing cycle.

Structure
REQ-029 Shared package quad_pkg SHALL hold the transition enum (NONE, INC, DEC, ILLEGAL) and default values of POS_W, POS_MAX, POS_INIT, DETENT.
REQ-030 One combinational sub-module quad_xition_decode SHALL map {prev_ab, cur_ab} to the transition enum; everything else lives in quad_position.

Verification
REQ-031 Reset, hold Ain=Bin=1 through release -> no step_pulse, no err_pulse, pos=320.
REQ-032 Drive {B,A} 00,01,11,10,00, each held 8 clk -> one step_pulse 2 clk after last edge, dir=1, pos=321.
REQ-033 Drive reverse sequence 4 detents from pos=1 -> 4 step_pulses, dir=0, pos=0 after first, stays 0, at_min=1.
REQ-034 Drive 00->11 -> err_pulse one cycle, pos and acc unchanged; subsequent legal detent still counts correctly.
REQ-035 Half detent (00,01,11) then reverse (01,00) -> no step_pulse, acc returns 0, pos unchanged.
REQ-036 recenter asserted same cycle a detent completes at pos=639 -> pos=320, step_pulse=0; rst_n low mid-detent -> pos=320, acc=0.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and defaults for the quadrature position tracker.
package quad_pkg;

  // Default parameter values for quad_position.
  localparam int DEF_POS_W    = 10;
  localparam int DEF_POS_MAX  = 639;
  localparam int DEF_POS_INIT = 320;
  localparam int DEF_DETENT   = 4;

  // Accumulator width: holds -(DETENT-1)..+(DETENT-1) for DETENT up to 4 with margin.
  localparam int ACC_W = 4;

  // Classification of one prev_ab -> cur_ab sample pair.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    INC     = 2'd1,
    DEC     = 2'd2,
    ILLEGAL = 2'd3
  } xition_e;

  // Map a {B,A} Gray code to its position in the clockwise cycle 00,01,11,10.
  // Subtracting two phases modulo 4 then gives the signed quarter-step distance.
  function automatic logic [1:0] gray_phase(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/quad_xition_decode.sv
// Combinational classifier of one quadrature sample pair into NONE/INC/DEC/ILLEGAL.
module quad_xition_decode
  import quad_pkg::*;
(
  input  logic [1:0] i_prev_ab,
  input  logic [1:0] i_cur_ab,
  output xition_e    o_xition
);

  logic [1:0] w_delta;

  // Phase difference modulo 4: +1 is clockwise, -1 (3) is counter-clockwise,
  // 2 means both channels flipped at once and the direction is unknowable.
  always_comb begin
    w_delta = gray_phase(i_cur_ab) - gray_phase(i_prev_ab);
    case (w_delta)
      2'd0:    o_xition = NONE;
      2'd1:    o_xition = INC;
      2'd3:    o_xition = DEC;
      default: o_xition = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/quad_position.sv
// Quadrature encoder to saturating cursor position with detent grouping.
// Pipeline: input sample register, then decode + output register, so an input
// edge completing a detent shows on step_pulse/pos two clock edges later.
module quad_position
  import quad_pkg::*;
#(
  parameter int POS_W    = DEF_POS_W,
  parameter int POS_MAX  = DEF_POS_MAX,
  parameter int POS_INIT = DEF_POS_INIT,
  parameter int DETENT   = DEF_DETENT   // quarter-steps per reported step: 1, 2 or 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Ain,
  input  logic             Bin,
  input  logic             recenter,
  output logic             step_pulse,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             at_min,
  output logic             at_max,
  output logic             err_pulse
);

  localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_INIT_V = POS_W'(POS_INIT);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  // Accumulator limits: reaching +/-DETENT wraps to zero and emits a step.
  localparam logic signed [ACC_W-1:0] ACC_TOP  = ACC_W'(DETENT - 1);
  localparam logic signed [ACC_W-1:0] ACC_BOT  = ACC_W'(1 - DETENT);
  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

  logic [1:0]              r_cur_ab;
  logic [1:0]              r_prev_ab;
  logic                    r_primed;   // low until the first post-reset sample is taken
  logic signed [ACC_W-1:0] r_acc;
  logic [POS_W-1:0]        r_pos;
  logic                    r_dir;
  logic                    r_step;
  logic                    r_err;

  xition_e                 w_xition;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_step_up;
  logic                    w_step_dn;
  logic                    w_err;
  logic [POS_W-1:0]        w_pos_next;

  quad_xition_decode u_decode (
    .i_prev_ab (r_prev_ab),
    .i_cur_ab  (r_cur_ab),
    .o_xition  (w_xition)
  );

  // Quarter-step accumulation, detent detection and saturating position update.
  always_comb begin
    w_acc_next = r_acc;
    w_step_up  = 1'b0;
    w_step_dn  = 1'b0;
    w_err      = 1'b0;
    w_pos_next = r_pos;
    // Until primed, prev/cur still hold the reset value and must not be decoded.
    if (r_primed) begin
      case (w_xition)
        INC: begin
          if (r_acc == ACC_TOP) begin
            w_acc_next = ACC_ZERO;
            w_step_up  = 1'b1;
          end else begin
            w_acc_next = r_acc + ACC_ONE;
          end
        end
        DEC: begin
          if (r_acc == ACC_BOT) begin
            w_acc_next = ACC_ZERO;
            w_step_dn  = 1'b1;
          end else begin
            w_acc_next = r_acc - ACC_ONE;
          end
        end
        ILLEGAL: w_err = 1'b1;  // acc, pos and dir deliberately untouched
        default: ;
      endcase
    end
    // A step at a bound is still reported; only the position holds.
    if (w_step_up && (r_pos != POS_MAX_V)) begin
      w_pos_next = r_pos + POS_ONE;
    end else if (w_step_dn && (r_pos != '0)) begin
      w_pos_next = r_pos - POS_ONE;
    end
  end

  // Input sampling, priming after reset, and registered outputs; recenter overrides stepping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur_ab  <= 2'b00;
      r_prev_ab <= 2'b00;
      r_primed  <= 1'b0;
      r_acc     <= ACC_ZERO;
      r_pos     <= POS_INIT_V;
      r_dir     <= 1'b0;
      r_step    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cur_ab  <= {Bin, Ain};
      // Prime cycle loads both samples from the input so the first decode sees NONE.
      r_prev_ab <= r_primed ? r_cur_ab : {Bin, Ain};
      r_primed  <= 1'b1;
      r_err     <= w_err;
      if (recenter) begin
        r_pos  <= POS_INIT_V;
        r_acc  <= ACC_ZERO;
        r_step <= 1'b0;
      end else begin
        r_pos  <= w_pos_next;
        r_acc  <= w_acc_next;
        r_step <= w_step_up | w_step_dn;
        if (w_step_up) begin
          r_dir <= 1'b1;
        end else if (w_step_dn) begin
          r_dir <= 1'b0;
        end
      end
    end
  end

  assign step_pulse = r_step;
  assign err_pulse  = r_err;
  assign dir        = r_dir;
  assign pos        = r_pos;
  assign at_min     = (r_pos == '0);
  assign at_max     = (r_pos == POS_MAX_V);

endmodule
